sdram_arbiter: RTL and testbench

//   Shares the single SoC-side port of sdram_controller between two masters (m0, m1).

---
 rtl/sdram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of sdram_controller's single SoC port.
// Picks one master, latches its command, strobes the controller once,
// then waits for the controller's ready (or a timeout) before returning
// read data and an ack/err pulse to the granted master.
module sdram_arbiter #(
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = 4,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_port,
    input  logic                  m0_req_port,
    input  logic                  m0_we_port,
    input  logic [ADDR_WIDTH-1:0] m0_addr_port,
    input  logic [DATA_WIDTH-1:0] m0_wr_data_port,
    input  logic [MASK_WIDTH-1:0] m0_wr_mask_port,
    output logic                  m0_ack_port,
    output logic                  m0_err_port,
    output logic [DATA_WIDTH-1:0] m0_rd_data_port,
    input  logic                  m1_req_port,
    input  logic                  m1_we_port,
    input  logic [ADDR_WIDTH-1:0] m1_addr_port,
    input  logic [DATA_WIDTH-1:0] m1_wr_data_port,
    input  logic [MASK_WIDTH-1:0] m1_wr_mask_port,
    output logic                  m1_ack_port,
    output logic                  m1_err_port,
    output logic [DATA_WIDTH-1:0] m1_rd_data_port,
    input  logic                  ctrl_busy_port,
    input  logic                  ctrl_ready_port,
    input  logic [DATA_WIDTH-1:0] ctrl_rd_data_port,
    output logic [ADDR_WIDTH-1:0] ctrl_addr_port,
    output logic [DATA_WIDTH-1:0] ctrl_wr_data_port,
    output logic [MASK_WIDTH-1:0] ctrl_wr_mask_port,
    output logic                  ctrl_wr_en_port,
    output logic                  ctrl_rd_en_port
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_grant;
    logic                  r_lastGrant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wrData;
    logic [MASK_WIDTH-1:0] r_wrMask;
    logic                  r_wrEn;
    logic                  r_rdEn;
    logic                  r_m0Ack;
    logic                  r_m1Ack;
    logic                  r_m0Err;
    logic                  r_m1Err;
    logic [DATA_WIDTH-1:0] r_m0RdData;
    logic [DATA_WIDTH-1:0] r_m1RdData;
    logic [CNT_W-1:0]      r_timeoutCnt;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_pick;
    logic                  w_grantNow;
    logic                  w_done;
    logic                  w_expire;
    logic                  w_pickWe;
    logic [ADDR_WIDTH-1:0] w_pickAddr;
    logic [DATA_WIDTH-1:0] w_pickData;
    logic [MASK_WIDTH-1:0] w_pickMask;

    assign w_pickWe   = w_pick ? m1_we_port      : m0_we_port;
    assign w_pickAddr = w_pick ? m1_addr_port    : m0_addr_port;
    assign w_pickData = w_pick ? m1_wr_data_port : m0_wr_data_port;
    assign w_pickMask = w_pick ? m1_wr_mask_port : m0_wr_mask_port;

    // Winner selection; a master being acked/erred this cycle sits out one cycle
    always_comb begin
        w_elig0 = m0_req_port & ~r_m0Ack & ~r_m0Err;
        w_elig1 = m1_req_port & ~r_m1Ack & ~r_m1Err;
        if (w_elig0 && w_elig1) begin
            w_pick = (PRIORITY_MODE != 0) ? 1'b0 : ~r_lastGrant;
        end else begin
            w_pick = w_elig1;
        end
    end

    // Next-state logic and the one-cycle decision flags for the datapath
    always_comb begin
        w_nextState = r_state;
        w_grantNow  = 1'b0;
        w_done      = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!ctrl_busy_port && (w_elig0 || w_elig1)) begin
                    w_grantNow  = 1'b1;
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (ctrl_ready_port) begin
                    w_done      = 1'b1;
                    w_nextState = S_IDLE;
                end else if (r_timeoutCnt == CNT_LAST) begin
                    w_expire    = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset_port) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Command latch and single-cycle controller strobes issued on grant
    always_ff @(posedge clk) begin
        if (reset_port) begin
            r_grant  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wrData <= '0;
            r_wrMask <= '0;
            r_wrEn   <= 1'b0;
            r_rdEn   <= 1'b0;
        end else begin
            r_wrEn <= w_grantNow & w_pickWe;
            r_rdEn <= w_grantNow & ~w_pickWe;
            if (w_grantNow) begin
                r_grant  <= w_pick;
                r_we     <= w_pickWe;
                r_addr   <= w_pickAddr;
                r_wrData <= w_pickData;
                r_wrMask <= w_pickMask;
            end
        end
    end

    // Completion: capture read data, pulse ack or err to the granted master
    always_ff @(posedge clk) begin
        if (reset_port) begin
            r_m0Ack     <= 1'b0;
            r_m1Ack     <= 1'b0;
            r_m0Err     <= 1'b0;
            r_m1Err     <= 1'b0;
            r_m0RdData  <= '0;
            r_m1RdData  <= '0;
            r_lastGrant <= 1'b1;
        end else begin
            r_m0Ack <= w_done & ~r_grant;
            r_m1Ack <= w_done & r_grant;
            r_m0Err <= w_expire & ~r_grant;
            r_m1Err <= w_expire & r_grant;
            if (w_done && !r_we && !r_grant) begin
                r_m0RdData <= ctrl_rd_data_port;
            end
            if (w_done && !r_we && r_grant) begin
                r_m1RdData <= ctrl_rd_data_port;
            end
            if (w_done || w_expire) begin
                r_lastGrant <= r_grant;
            end
        end
    end

    // Timeout counter: cleared while issuing, counts idle WAIT cycles
    always_ff @(posedge clk) begin
        if (reset_port) begin
            r_timeoutCnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_timeoutCnt <= '0;
        end else if (r_state == S_WAIT && !w_done && !w_expire) begin
            r_timeoutCnt <= r_timeoutCnt + CNT_W'(1);
        end
    end

    assign m0_ack_port       = r_m0Ack;
    assign m1_ack_port       = r_m1Ack;
    assign m0_err_port       = r_m0Err;
    assign m1_err_port       = r_m1Err;
    assign m0_rd_data_port   = r_m0RdData;
    assign m1_rd_data_port   = r_m1RdData;
    assign ctrl_addr_port    = r_addr;
    assign ctrl_wr_data_port = r_wrData;
    assign ctrl_wr_mask_port = r_wrMask;
    assign ctrl_wr_en_port   = r_wrEn;
    assign ctrl_rd_en_port   = r_rdEn;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a round-robin instance driven by a
// hand-timed controller model, plus a fixed-priority instance with a small
// automatic controller model that inserts a busy gap after each completion.
module tb_sdram_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 32;

    logic          clk;
    logic          reset;
    logic          m0Req, m1Req, m0We, m1We;
    logic [AW-1:0] m0Addr, m1Addr;
    logic [DW-1:0] m0WrData, m1WrData;
    logic [MW-1:0] m0WrMask, m1WrMask;

    logic          m0Ack, m1Ack, m0Err, m1Err;
    logic [DW-1:0] m0RdData, m1RdData;
    logic          ctrlBusy, ctrlReady;
    logic [DW-1:0] ctrlRdData;
    logic [AW-1:0] ctrlAddr;
    logic [DW-1:0] ctrlWrData;
    logic [MW-1:0] ctrlWrMask;
    logic          ctrlWrEn, ctrlRdEn;

    logic          priM0Ack, priM1Ack, priM0Err, priM1Err;
    logic [DW-1:0] priM0RdData, priM1RdData;
    logic          priBusy, priReady;
    logic [DW-1:0] priCtrlRdData;
    logic [AW-1:0] priAddr;
    logic [DW-1:0] priWrData;
    logic [MW-1:0] priWrMask;
    logic          priWrEn, priRdEn;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] expRd [2];
    int            priAck0 = 0;
    int            priAck1 = 0;
    logic          priCountEn = 1'b0;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                    .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .reset_port(reset),
        .m0_req_port(m0Req), .m0_we_port(m0We), .m0_addr_port(m0Addr),
        .m0_wr_data_port(m0WrData), .m0_wr_mask_port(m0WrMask),
        .m0_ack_port(m0Ack), .m0_err_port(m0Err), .m0_rd_data_port(m0RdData),
        .m1_req_port(m1Req), .m1_we_port(m1We), .m1_addr_port(m1Addr),
        .m1_wr_data_port(m1WrData), .m1_wr_mask_port(m1WrMask),
        .m1_ack_port(m1Ack), .m1_err_port(m1Err), .m1_rd_data_port(m1RdData),
        .ctrl_busy_port(ctrlBusy), .ctrl_ready_port(ctrlReady),
        .ctrl_rd_data_port(ctrlRdData), .ctrl_addr_port(ctrlAddr),
        .ctrl_wr_data_port(ctrlWrData), .ctrl_wr_mask_port(ctrlWrMask),
        .ctrl_wr_en_port(ctrlWrEn), .ctrl_rd_en_port(ctrlRdEn)
    );

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                    .PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO)) u_dutPri (
        .clk(clk), .reset_port(reset),
        .m0_req_port(m0Req), .m0_we_port(m0We), .m0_addr_port(m0Addr),
        .m0_wr_data_port(m0WrData), .m0_wr_mask_port(m0WrMask),
        .m0_ack_port(priM0Ack), .m0_err_port(priM0Err), .m0_rd_data_port(priM0RdData),
        .m1_req_port(m1Req), .m1_we_port(m1We), .m1_addr_port(m1Addr),
        .m1_wr_data_port(m1WrData), .m1_wr_mask_port(m1WrMask),
        .m1_ack_port(priM1Ack), .m1_err_port(priM1Err), .m1_rd_data_port(priM1RdData),
        .ctrl_busy_port(priBusy), .ctrl_ready_port(priReady),
        .ctrl_rd_data_port(priCtrlRdData), .ctrl_addr_port(priAddr),
        .ctrl_wr_data_port(priWrData), .ctrl_wr_mask_port(priWrMask),
        .ctrl_wr_en_port(priWrEn), .ctrl_rd_en_port(priRdEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Priority-instance controller: ready two cycles after a strobe, then two busy cycles
    initial begin
        int delay;
        int busyCnt;
        delay = 0;
        busyCnt = 0;
        priBusy = 1'b0;
        priReady = 1'b0;
        priCtrlRdData = 32'h0;
        forever begin
            @(negedge clk);
            if (busyCnt > 0) busyCnt--;
            if (priReady) begin
                priReady = 1'b0;
                busyCnt = 2;
            end else if (priRdEn || priWrEn) begin
                delay = 2;
            end else if (delay > 0) begin
                delay--;
                if (delay == 0) priReady = 1'b1;
            end
            priBusy = (busyCnt > 0);
        end
    end

    // Count grants completed by the priority instance while enabled
    initial begin
        forever begin
            @(negedge clk);
            if (priCountEn) begin
                if (priM0Ack) priAck0++;
                if (priM1Ack) priAck1++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int master, input logic req, input logic we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input logic [MW-1:0] mask);
        if (master == 0) begin
            m0Req = req; m0We = we; m0Addr = addr; m0WrData = data; m0WrMask = mask;
        end else begin
            m1Req = req; m1We = we; m1Addr = addr; m1WrData = data; m1WrMask = mask;
        end
    endtask

    task automatic waitStrobe(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (ctrlRdEn || ctrlWrEn) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic completeTxn(input int master, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [MW-1:0] mask,
                               input int readyDelay, input logic [DW-1:0] rdData,
                               input logic dropReq, input string tag, output int cyc);
        int other;
        other = 1 - master;
        waitStrobe(cyc);
        checkOutput({tag, "_strobe_seen"}, (cyc >= 0), 1);
        if (cyc < 0) return;
        checkOutput({tag, "_strobe_kind"}, {ctrlWrEn, ctrlRdEn}, we ? 2'b10 : 2'b01);
        checkOutput({tag, "_addr"}, ctrlAddr, addr);
        if (we) begin
            checkOutput({tag, "_wr_data"}, ctrlWrData, data);
            checkOutput({tag, "_wr_mask"}, ctrlWrMask, mask);
        end
        @(negedge clk);
        checkOutput({tag, "_strobe_1cyc"}, {ctrlWrEn, ctrlRdEn}, 2'b00);
        repeat (readyDelay - 1) @(negedge clk);
        ctrlReady = 1'b1;
        ctrlRdData = rdData;
        @(negedge clk);
        ctrlReady = 1'b0;
        ctrlRdData = 32'h0;
        checkOutput({tag, "_acks"}, {m1Ack, m0Ack}, (master == 1) ? 2'b10 : 2'b01);
        checkOutput({tag, "_errs"}, {m1Err, m0Err}, 2'b00);
        if (!we) expRd[master] = rdData;
        checkOutput({tag, "_rd_own"}, (master == 1) ? m1RdData : m0RdData, expRd[master]);
        checkOutput({tag, "_rd_other"}, (other == 1) ? m1RdData : m0RdData, expRd[other]);
        if (dropReq) applyStimulus(master, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int cyc;
        int n;
        int events;
        reset = 1'b1;
        ctrlBusy = 1'b0;
        ctrlReady = 1'b0;
        ctrlRdData = 32'h0;
        expRd[0] = 32'h0;
        expRd[1] = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] test 1: request under reset");
        applyStimulus(0, 1'b1, 1'b0, 23'h111, 32'h0, 4'h0);
        events = 0;
        repeat (4) begin
            @(negedge clk);
            if (ctrlRdEn || ctrlWrEn || m0Ack || m0Err) events++;
        end
        checkOutput("t1_quiet_in_reset", events, 0);
        checkOutput("t1_reset_addr", ctrlAddr, 0);
        checkOutput("t1_reset_rd0", m0RdData, 0);
        reset = 1'b0;
        completeTxn(0, 1'b0, 23'h111, 32'h0, 4'h0, 2, 32'hCAFE0001, 1'b1, "t1", cyc);
        checkOutput("t1_strobe_latency", cyc, 1);
        @(negedge clk);

        $display("[TB] test 2: m0 write");
        applyStimulus(0, 1'b1, 1'b1, 23'h0000AA, 32'hDEADBEEF, 4'b0000);
        completeTxn(0, 1'b1, 23'h0000AA, 32'hDEADBEEF, 4'b0000, 5, 32'h0, 1'b1, "t2", cyc);
        @(negedge clk);
        checkOutput("t2_ack_1cyc", {m1Ack, m0Ack}, 2'b00);

        $display("[TB] test 3: both masters continuously");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        expRd[0] = 32'h0;
        expRd[1] = 32'h0;
        applyStimulus(0, 1'b1, 1'b0, 23'h100, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 23'h200, 32'h0, 4'h0);
        priAck0 = 0;
        priAck1 = 0;
        priCountEn = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            completeTxn(i % 2, 1'b0, (i % 2 == 1) ? 23'h200 : 23'h100, 32'h0, 4'h0,
                        3, 32'hA0 + 32'(i), 1'b0, $sformatf("t3_g%0d", i), cyc);
        end
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        priCountEn = 1'b0;
        checkOutput("t3_pri_m1_never", priAck1, 0);
        checkOutput("t3_pri_m0_served", (priAck0 >= 2), 1);
        @(negedge clk);

        $display("[TB] test 4/5: m1 read behind refresh busy");
        ctrlBusy = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 23'h333, 32'h0, 4'h0);
        events = 0;
        repeat (200) begin
            @(negedge clk);
            if (ctrlRdEn || ctrlWrEn) events++;
        end
        checkOutput("t4_no_strobe_busy", events, 0);
        ctrlBusy = 1'b0;
        completeTxn(1, 1'b0, 23'h333, 32'h0, 4'h0, 2, 32'h12345678, 1'b1, "t5", cyc);
        checkOutput("t4_strobe_after_busy", cyc, 1);
        checkOutput("t5_m1_rd", m1RdData, 32'h12345678);
        checkOutput("t5_m0_rd_kept", m0RdData, 32'hA2);
        @(negedge clk);

        $display("[TB] test 6: timeout then late ready");
        applyStimulus(0, 1'b1, 1'b0, 23'h444, 32'h0, 4'h0);
        waitStrobe(cyc);
        checkOutput("t6_strobe_seen", (cyc >= 0), 1);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (m0Err || m0Ack) begin
                n = i;
                break;
            end
        end
        checkOutput("t6_err_latency", n, TO + 1);
        checkOutput("t6_err_not_ack", {m1Err, m1Ack, m0Err, m0Ack}, 4'b0010);
        applyStimulus(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t6_err_1cyc", m0Err, 0);
        ctrlReady = 1'b1;
        ctrlRdData = 32'hBADBAD00;
        @(negedge clk);
        ctrlReady = 1'b0;
        events = 0;
        repeat (6) begin
            if (m0Ack || m1Ack || m0Err || m1Err || ctrlRdEn || ctrlWrEn) events++;
            @(negedge clk);
        end
        checkOutput("t6_late_ready_ignored", events, 0);
        checkOutput("t6_rd_unchanged", m0RdData, 32'hA2);

        $display("[TB] test 6b: reset during WAIT");
        applyStimulus(1, 1'b1, 1'b0, 23'h555, 32'h0, 4'h0);
        waitStrobe(cyc);
        checkOutput("t6b_strobe_seen", (cyc >= 0), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ctrlReady = 1'b1;
        @(negedge clk);
        ctrlReady = 1'b0;
        events = 0;
        repeat (TO + 10) begin
            if (m0Ack || m1Ack || m0Err || m1Err || ctrlRdEn || ctrlWrEn) events++;
            @(negedge clk);
        end
        checkOutput("t6b_silent_abort", events, 0);
        checkOutput("t6b_addr_cleared", ctrlAddr, 0);
        checkOutput("t6b_rd1_cleared", m1RdData, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
